// File: rtl/dot_accumulator_64b.sv
// Dot-product accumulator fed by a 32x32 single-cycle multiplier.
// Sums a programmed number of 64-bit products into a wide unsigned accumulator.
module dot_accumulator_64b #(
    parameter int ACC_WIDTH = 80,
    parameter int LEN_WIDTH = 16
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iClr,
    input  logic                 iStart,
    input  logic [LEN_WIDTH-1:0] iLen,
    input  logic                 iEn,
    input  logic [63:0]          iProd,
    output logic                 oBusy,
    output logic                 oDone,
    output logic [ACC_WIDTH-1:0] oAcc,
    output logic [LEN_WIDTH-1:0] oCnt,
    output logic                 oOvf
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic                   ovf_q, ovf_d;
    logic                   en_dly_q;
    logic [ACC_WIDTH:0]     sum;
    logic [LEN_WIDTH-1:0]   cnt_inc;

    // Extra top bit catches the carry out of the accumulator.
    assign sum     = {1'b0, acc_q} + (ACC_WIDTH+1)'(iProd);
    assign cnt_inc = cnt_q + LEN_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (iStart) begin
                    len_d   = iLen;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (iLen == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // en_dly_q marks the cycle the multiplier output belongs to us.
                if (en_dly_q) begin
                    acc_d = sum[ACC_WIDTH-1:0];
                    ovf_d = ovf_q | sum[ACC_WIDTH];
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q)
                        state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst || iClr) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            ovf_q    <= 1'b0;
            en_dly_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            ovf_q    <= ovf_d;
            en_dly_q <= iEn;
        end
    end

    assign oBusy = (state_q == RUN);
    assign oDone = (state_q == DONE);
    assign oAcc  = acc_q;
    assign oCnt  = cnt_q;
    assign oOvf  = ovf_q;

endmodule

// File: tb/tb_dot_accumulator_64b.sv
// Drives an 80-bit and a 64-bit accumulator with identical stimulus and checks
// both every cycle against a job-level reference model.
module tb_dot_accumulator_64b;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        iClr = 1'b0;
    logic        iStart = 1'b0;
    logic [15:0] iLen = '0;
    logic        iEn = 1'b0;
    logic [63:0] iProd = '0;

    logic        busyA, doneA, ovfA, busyB, doneB, ovfB;
    logic [79:0] accA;
    logic [63:0] accB;
    logic [15:0] cntA, cntB;

    int n_assert = 0;
    int n_fail   = 0;

    dot_accumulator_64b #(.ACC_WIDTH(80), .LEN_WIDTH(16)) dutA (
        .iClk(iClk), .iRst(iRst), .iClr(iClr), .iStart(iStart), .iLen(iLen),
        .iEn(iEn), .iProd(iProd), .oBusy(busyA), .oDone(doneA), .oAcc(accA),
        .oCnt(cntA), .oOvf(ovfA));

    dot_accumulator_64b #(.ACC_WIDTH(64), .LEN_WIDTH(16)) dutB (
        .iClk(iClk), .iRst(iRst), .iClr(iClr), .iStart(iStart), .iLen(iLen),
        .iEn(iEn), .iProd(iProd), .oBusy(busyB), .oDone(doneB), .oAcc(accB),
        .oCnt(cntB), .oOvf(ovfB));

    always #5 iClk = ~iClk;

    // Reference model: index 0 is the 80-bit instance, 1 the 64-bit one.
    // phase: 0 = no job active, 1 = collecting terms, 2 = result just finished.
    int           m_phase [2];
    int           m_need  [2];
    int           m_got   [2];
    logic [127:0] m_sum   [2];
    logic         m_ovf   [2];
    logic         m_prev_en;
    int           W [2] = '{80, 64};

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0; m_need[k] = 0; m_got[k] = 0; m_sum[k] = '0; m_ovf[k] = 1'b0;
        end
        m_prev_en = 1'b0;
    end

    always @(posedge iClk) begin
        for (int k = 0; k < 2; k++) begin
            logic [127:0] full;
            logic [127:0] mask;
            mask = (128'd1 << W[k]) - 128'd1;
            if (iRst || iClr) begin
                m_phase[k] = 0; m_need[k] = 0; m_got[k] = 0; m_sum[k] = '0; m_ovf[k] = 1'b0;
            end else if (m_phase[k] == 2) begin
                m_phase[k] = 0;
            end else if (m_phase[k] == 0) begin
                if (iStart) begin
                    m_need[k] = int'(iLen); m_got[k] = 0; m_sum[k] = '0; m_ovf[k] = 1'b0;
                    m_phase[k] = (iLen == 16'd0) ? 2 : 1;
                end
            end else if (m_prev_en) begin
                // The product on the bus now belongs to last cycle's enable.
                full = m_sum[k] + {64'd0, iProd};
                if ((full & ~mask) != 128'd0) m_ovf[k] = 1'b1;
                m_sum[k] = full & mask;
                m_got[k] = m_got[k] + 1;
                if (m_got[k] == m_need[k]) m_phase[k] = 2;
            end
        end
        m_prev_en = (iRst || iClr) ? 1'b0 : iEn;
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_cycle();
        chk("A.busy", {127'd0, busyA}, {127'd0, m_phase[0] == 1});
        chk("A.done", {127'd0, doneA}, {127'd0, m_phase[0] == 2});
        chk("A.acc",  {48'd0, accA},   m_sum[0]);
        chk("A.cnt",  {112'd0, cntA},  128'(m_got[0]));
        chk("A.ovf",  {127'd0, ovfA},  {127'd0, m_ovf[0]});
        chk("B.busy", {127'd0, busyB}, {127'd0, m_phase[1] == 1});
        chk("B.done", {127'd0, doneB}, {127'd0, m_phase[1] == 2});
        chk("B.acc",  {64'd0, accB},   m_sum[1]);
        chk("B.cnt",  {112'd0, cntB},  128'(m_got[1]));
        chk("B.ovf",  {127'd0, ovfB},  {127'd0, m_ovf[1]});
    endtask

    logic [63:0] pend_prod = '0;

    // One clock: apply inputs, let the edge happen, check. iProd carries the
    // product of the previous cycle's enable (junk when that enable was low).
    task automatic step(input logic st, input int len, input logic en, input logic [63:0] prod,
                        input logic clr = 1'b0, input logic rst = 1'b0);
        iStart = st; iLen = 16'(len); iEn = en; iClr = clr; iRst = rst;
        iProd = pend_prod;
        pend_prod = en ? prod : {$urandom, $urandom};
        @(posedge iClk);
        #1;
        cmp_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 64'd0);
    endtask

    initial begin
        // Reset
        step(1'b0, 0, 1'b0, 64'd0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 64'd0, 1'b0, 1'b1);
        chk("reset.acc", {48'd0, accA}, 128'd0);
        chk("reset.busy", {127'd0, busyA}, 128'd0);
        idle(2);

        // Basic run: 3+5+7+9, done at start+5
        step(1'b1, 4, 1'b1, 64'd3);
        step(1'b0, 0, 1'b1, 64'd5);
        step(1'b0, 0, 1'b1, 64'd7);
        step(1'b0, 0, 1'b1, 64'd9);
        chk("basic.notdone", {127'd0, doneA}, 128'd0);
        step(1'b0, 0, 1'b0, 64'd0);
        chk("basic.done", {127'd0, doneA}, 128'd1);
        chk("basic.acc",  {48'd0, accA}, 128'd24);
        chk("basic.cnt",  {112'd0, cntA}, 128'd4);
        step(1'b0, 0, 1'b0, 64'd0);
        chk("basic.busy_after", {127'd0, busyA}, 128'd0);
        chk("basic.hold", {48'd0, accA}, 128'd24);
        idle(1);

        // Bubbles and trailing products
        begin
            logic [6:0] pat;
            pat = 7'b1101001;
            for (int i = 0; i < 7; i++)
                step(i == 0, 3, pat[i], 64'hFFFFFFFF_00000001);
        end
        idle(2);
        chk("bubble.acc", {48'd0, accA}, 128'h2_FFFFFFFD_00000003);
        chk("bubble.cnt", {112'd0, cntA}, 128'd3);
        chk("bubble.ovfB", {127'd0, ovfB}, 128'd1);

        // Zero length with a stale product ahead of it
        step(1'b0, 0, 1'b1, 64'd77);
        step(1'b1, 0, 1'b0, 64'd0);
        chk("zero.done", {127'd0, doneA}, 128'd1);
        chk("zero.acc", {48'd0, accA}, 128'd0);
        idle(1);
        step(1'b0, 0, 1'b1, 64'd100);
        step(1'b1, 1, 1'b1, 64'd5);
        step(1'b0, 0, 1'b0, 64'd0);
        chk("stale.acc", {48'd0, accA}, 128'd5);
        idle(1);

        // Overflow on the 64-bit instance
        step(1'b1, 2, 1'b1, 64'hFFFFFFFF_FFFFFFFF);
        step(1'b0, 0, 1'b1, 64'd2);
        idle(2);
        chk("ovf.accB", {64'd0, accB}, 128'd1);
        chk("ovf.flagB", {127'd0, ovfB}, 128'd1);
        chk("ovf.accA", {48'd0, accA}, 128'h1_00000000_00000001);
        step(1'b1, 3, 1'b0, 64'd0);
        chk("ovf.cleared", {127'd0, ovfB}, 128'd0);
        step(1'b0, 0, 1'b0, 64'd0, 1'b1, 1'b0);

        // Abort by clear, then by reset
        step(1'b1, 5, 1'b1, 64'd11);
        step(1'b0, 0, 1'b1, 64'd12);
        step(1'b0, 0, 1'b1, 64'd13);
        step(1'b0, 0, 1'b1, 64'd14, 1'b1, 1'b0);
        chk("clr.acc", {48'd0, accA}, 128'd0);
        chk("clr.busy", {127'd0, busyA}, 128'd0);
        idle(3);
        step(1'b1, 5, 1'b1, 64'd21);
        step(1'b0, 0, 1'b1, 64'd22);
        step(1'b0, 0, 1'b1, 64'd23, 1'b0, 1'b1);
        chk("rst.cnt", {112'd0, cntA}, 128'd0);
        idle(3);
        step(1'b1, 2, 1'b1, 64'd1, 1'b1, 1'b0);
        chk("clrstart.busy", {127'd0, busyA}, 128'd0);
        idle(3);

        // Start while busy
        step(1'b1, 3, 1'b1, 64'd100);
        step(1'b1, 9, 1'b1, 64'd200);
        step(1'b0, 0, 1'b1, 64'd300);
        step(1'b1, 9, 1'b1, 64'd400);
        chk("busy.done", {127'd0, doneA}, 128'd1);
        chk("busy.cnt", {112'd0, cntA}, 128'd3);
        chk("busy.acc", {48'd0, accA}, 128'd600);
        idle(4);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic [63:0] p;
            p = ($urandom_range(0, 3) == 0) ? 64'hFFFFFFFF_FFFFFFFF - 64'($urandom_range(0, 3))
                                            : {$urandom, $urandom};
            step($urandom_range(0, 7) == 0, int'($urandom_range(0, 6)),
                 $urandom_range(0, 3) != 0, p,
                 $urandom_range(0, 79) == 0, $urandom_range(0, 299) == 0);
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dot_accumulator_64b.md
Name: dot_accumulator_64b

Overview:
- Sits directly downstream of the 32x32 single-cycle multiplier and consumes its 64-bit product stream.
- Sums a programmed number of consecutive products into a wide unsigned accumulator to form a dot product.
- Reports completion with a one-cycle done pulse, the held result, and a sticky overflow flag.
- Tracks the multiplier's 1-cycle latency internally by registering the same enable that drives the multiplier.

Parameters:
- ACC_WIDTH, 80, accumulator/result width in bits; must be >= 64.
- LEN_WIDTH, 16, width of the term-count input and counter.

Ports:
- iClk  input  1  clock; all logic on rising edge.
- iRst  input  1  synchronous reset, active-high.
- iClr  input  1  synchronous abort/clear.
- iStart  input  1  start a new dot product; accepted only in IDLE.
- iLen  input  LEN_WIDTH  number of products to sum; sampled on accepted iStart.
- iEn  input  1  the enable driven to the multiplier this cycle.
- iProd  input  64  multiplier oData, valid one cycle after the matching iEn.
- oBusy  output  1  high while in RUN.
- oDone  output  1  one-cycle pulse when the result is final.
- oAcc  output  ACC_WIDTH  accumulated result.
- oCnt  output  LEN_WIDTH  products accumulated so far.
- oOvf  output  1  sticky carry-out of the accumulator.

Behaviour:
- Reset: iRst synchronous, active-high, with highest priority. Sets state=IDLE and clears oAcc, oCnt, oOvf, oDone, oBusy, enD, and the latched length.
- enD: register of iEn, updated every cycle except during reset/clear. A product is consumed in cycle t+1 iff iEn=1 at cycle t.
- iClr: second priority. Same clearing as reset: state to IDLE, in-flight run abandoned, no oDone.
- FSM states IDLE, RUN, DONE:
  - IDLE:
    - On iStart: latch iLen, clear oAcc/oCnt/oOvf.
    - If iLen==0, go to DONE (result 0); otherwise go to RUN.
    - enD has no effect in IDLE. A product from iEn asserted before the iStart cycle is discarded.
  - RUN (oBusy=1):
    - When enD=1: oAcc <= oAcc + zero-extend(iProd), oCnt <= oCnt+1.
    - On the enD cycle where oCnt==len-1 the final add happens, then go to DONE.
    - enD=0 cycles are bubbles: no change.
    - An iEn asserted in the same cycle as the accepted iStart is counted as the first term.
  - DONE: oDone=1 for exactly this cycle, then unconditionally IDLE.
- iStart rules:
  - iStart in RUN or DONE is ignored; iLen is not re-sampled.
  - An iStart in the same cycle as iClr is ignored (clear wins).
- Extra products: iEn beyond the programmed count (products arriving in DONE/IDLE) are ignored.
- Result hold: oAcc and oCnt hold their final values in IDLE until the next accepted iStart, iClr, or iRst.
- Arithmetic:
  - Unsigned throughout.
  - A carry out of bit ACC_WIDTH-1 sets oOvf, which stays set until the next start, clear, or reset.
  - The accumulator wraps modulo 2^ACC_WIDTH.
- Throughput and latency:
  - One product per cycle.
  - A run of N back-to-back products starting with iEn on the iStart cycle s: oDone is high at cycle s+N+1.
  - New iStart accepted at s+N+2 at the earliest.

Test Plan:
- Basic run: iStart with iLen=4 and iEn on 4 consecutive cycles starting at the iStart cycle, products 3,5,7,9 -> oDone at start+5, oAcc=24, oCnt=4, oOvf=0, oBusy low after.
- Bubbles and trailing products: iLen=3 with iEn pattern 1,0,0,1,0,1,1, products 0xFFFFFFFF_00000001 each -> oAcc=0x2_FFFFFFFD_00000003, oDone once; the 4th product is ignored.
- Zero length and stale product: iStart with iLen=0 -> oDone next cycle, oAcc=0, oBusy never high. A product whose iEn preceded iStart is not counted.
- Overflow with ACC_WIDTH=64: iLen=2, products 0xFFFFFFFF_FFFFFFFF and 2 -> oAcc=1, oOvf=1. The next iStart clears oOvf.
- Abort mid-run: iClr after 2 of 5 products, then iRst mid-run of a second job -> IDLE, oAcc=0, oCnt=0, no oDone. Also a simultaneous iClr+iStart in IDLE -> stays IDLE.
- Start while busy: iStart with iLen=9 during RUN of iLen=3 -> ignored, run completes with count 3, no second oDone.
